// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter in front of an asynchronous byte-wide SRAM. Port A (CPU)
// and port B (DMA/video) each issue single-byte read or write requests. They
// are served one at a time through a fixed four-phase access:
//
//   IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles) -> HOLD (1 cycle)
//
// SETUP presents the address (and write data) before the strobe. ACCESS
// holds the write strobe low for writes, or waits out the SRAM access time
// for reads. HOLD keeps the address and data stable after the strobe rises
// and pulses the winning port's ack. Simultaneous requests are resolved
// round-robin.
//
// The winner's address, write flag and data are latched at grant. Requesters
// may therefore change their fields after grant without disturbing the
// access in flight.
//
// Parameters
//   WAIT_CYCLES  cycles spent in ACCESS (legal 1..15, held in a 4-bit counter)
//
// Ports
//   clk_chipset  sole clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   a_req/a_we   port A request and write flag (held until a_ack)
//   a_addr       port A 20-bit byte address (bit 19 = bank select)
//   a_wdata      port A write data
//   a_ack        port A one-cycle completion pulse (during HOLD)
//   a_rdata      port A read data, valid with a_ack, held until next read
//   b_*          port B, same meaning as port A
//   sram_addr    SRAM address, {1'b0, latched 20-bit address}
//   sram_we_n    SRAM write strobe, active-low, low only in ACCESS of a write
//   sram_dout    write data towards the SRAM
//   sram_oe      data-bus drive enable, high through SETUP/ACCESS/HOLD of a write
//   sram_din     read data from the SRAM
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_chipset,
  input  logic        reset_n,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [19:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [19:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,

  output logic [20:0] sram_addr,
  output logic        sram_we_n,
  output logic [7:0]  sram_dout,
  output logic        sram_oe,
  input  logic [7:0]  sram_din
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Terminal value of the ACCESS counter: it runs 0 .. WAIT_CYCLES-1.
  localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  port_t       last_grant_q;     // port served by the current/most recent access
  port_t       winner;           // port that would be granted this cycle
  logic        any_req;
  logic        access_done;
  logic [3:0]  cnt_q;

  // Request fields captured at grant; the SRAM side only ever sees these.
  logic [19:0] lat_addr_q;
  logic        lat_we_q;
  logic [7:0]  lat_wdata_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A lone requester always wins. On a tie, the port that was not served last
  // wins, so continuous dual requests alternate A, B, A, B. last_grant resets
  // to B, which hands the first tie after reset to A.
  assign any_req = a_req | b_req;

  always_comb begin
    if (a_req && (!b_req || last_grant_q == PORT_B)) begin
      winner = PORT_A;
    end else begin
      winner = PORT_B;
    end
  end

  assign access_done = (cnt_q == LAST_COUNT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments, so all
  // registers update together from values sampled before the edge; blocking
  // assignments here would make results depend on process evaluation order.
  always_ff @(posedge clk_chipset) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case, so every path assigns it
  // and no latch is inferred for combinational outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req)     state_d = SETUP;
      SETUP:                    state_d = ACCESS;
      ACCESS:  if (access_done) state_d = HOLD;
      HOLD:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant latch, ACCESS counter and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_chipset) begin
    if (!reset_n) begin
      last_grant_q <= PORT_B;
      lat_addr_q   <= '0;
      lat_we_q     <= 1'b0;
      lat_wdata_q  <= '0;
      cnt_q        <= '0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      // Latch the winner's fields only when leaving IDLE. Outside IDLE the
      // request inputs are ignored, so late changes cannot reach the SRAM.
      if (state_q == IDLE && any_req) begin
        last_grant_q <= winner;
        if (winner == PORT_A) begin
          lat_addr_q  <= a_addr;
          lat_we_q    <= a_we;
          lat_wdata_q <= a_wdata;
        end else begin
          lat_addr_q  <= b_addr;
          lat_we_q    <= b_we;
          lat_wdata_q <= b_wdata;
        end
      end

      // The counter runs only in ACCESS and is parked at zero otherwise, so
      // every access starts counting from a known value.
      if (state_q == ACCESS && !access_done) begin
        cnt_q <= cnt_q + 4'd1;
      end else begin
        cnt_q <= '0;
      end

      // Read data is sampled on the edge that ends the last ACCESS cycle.
      // That gives the SRAM the full WAIT_CYCLES to drive the bus, and the
      // data is valid during HOLD, when ack is pulsed. Each port's rdata
      // keeps its value until that port's next read completes.
      if (state_q == ACCESS && access_done && !lat_we_q) begin
        if (last_grant_q == PORT_A) begin
          a_rdata <= sram_din;
        end else begin
          b_rdata <= sram_din;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM-side and ack outputs
  // ---------------------------------------------------------------------------
  // All outputs decode directly from the state register and the grant latch.
  // The address and data registers change only at grant, that is, on the
  // IDLE -> SETUP edge. So sram_addr holds its value through IDLE and cannot
  // move while sram_we_n is low. Reset forces IDLE, which raises sram_we_n
  // and drops sram_oe from the first reset edge on, aborting any access.
  assign sram_addr = {1'b0, lat_addr_q};
  assign sram_dout = lat_wdata_q;
  assign sram_we_n = !(state_q == ACCESS && lat_we_q);
  assign sram_oe   = lat_we_q && (state_q != IDLE);

  assign a_ack = (state_q == HOLD) && (last_grant_q == PORT_A);
  assign b_ack = (state_q == HOLD) && (last_grant_q == PORT_B);

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Scoreboarded bench for sram_arbiter. The main instance (WAIT_CYCLES = 2)
// sits on a behavioural SRAM model. Stimulus tasks push the expected
// completion (port, address, read data, ack cycle) for each request into a
// queue. An independent negedge monitor pops one entry per ack and compares
// it with what the DUT presents. The monitor also measures the strobe and
// drive-enable widths of each transaction. Two further instances
// (WAIT_CYCLES = 1 and 15) check strobe width and ack latency at the
// parameter limits.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        a_req, a_we, b_req, b_we;
  logic [19:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [7:0]  a_rdata, b_rdata;
  logic [20:0] sram_addr;
  logic        sram_we_n, sram_oe;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din = 8'h00;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk_chipset (clk),
    .reset_n     (reset_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_ack       (a_ack),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_ack       (b_ack),
    .b_rdata     (b_rdata),
    .sram_addr   (sram_addr),
    .sram_we_n   (sram_we_n),
    .sram_dout   (sram_dout),
    .sram_oe     (sram_oe),
    .sram_din    (sram_din)
  );

  // Parameter-limit instances: port A writes only, port B idle.
  logic        x_req   [2];
  logic        x_ack   [2];
  logic        x_back  [2];
  logic [7:0]  x_ardata[2];
  logic [7:0]  x_brdata[2];
  logic [20:0] x_addr  [2];
  logic        x_we_n  [2];
  logic [7:0]  x_dout  [2];
  logic        x_oe    [2];

  sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .clk_chipset (clk),        .reset_n   (reset_n),
    .a_req       (x_req[0]),   .a_we      (1'b1),
    .a_addr      (20'h00042),  .a_wdata   (8'h24),
    .a_ack       (x_ack[0]),   .a_rdata   (x_ardata[0]),
    .b_req       (1'b0),       .b_we      (1'b0),
    .b_addr      (20'h00000),  .b_wdata   (8'h00),
    .b_ack       (x_back[0]),  .b_rdata   (x_brdata[0]),
    .sram_addr   (x_addr[0]),  .sram_we_n (x_we_n[0]),
    .sram_dout   (x_dout[0]),  .sram_oe   (x_oe[0]),
    .sram_din    (8'h00)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .clk_chipset (clk),        .reset_n   (reset_n),
    .a_req       (x_req[1]),   .a_we      (1'b1),
    .a_addr      (20'h00042),  .a_wdata   (8'h24),
    .a_ack       (x_ack[1]),   .a_rdata   (x_ardata[1]),
    .b_req       (1'b0),       .b_we      (1'b0),
    .b_addr      (20'h00000),  .b_wdata   (8'h00),
    .b_ack       (x_back[1]),  .b_rdata   (x_brdata[1]),
    .sram_addr   (x_addr[1]),  .sram_we_n (x_we_n[1]),
    .sram_dout   (x_dout[1]),  .sram_oe   (x_oe[1]),
    .sram_din    (8'h00)
  );

  // ---------------------------------------------------------------------------
  // SRAM model: writes on rising edges while the strobe is low. Read data is
  // refreshed on the falling edge, ahead of the DUT's capture edge. A few
  // locations hold fixed contents until they are written.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [logic [20:0]];

  function automatic logic [7:0] preload(input logic [20:0] addr);
    case (addr)
      21'h000010: return 8'hC3;
      21'h000777: return 8'hEE;
      default:    return 8'h00;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    if (!sram_we_n) mem[sram_addr] = sram_dout;
  end

  initial forever begin
    @(negedge clk);
    sram_din = mem.exists(sram_addr) ? mem[sram_addr] : preload(sram_addr);
  end

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          port;   // 0 = A, 1 = B
    bit          we;
    logic [20:0] addr;
    logic [7:0]  rdata;
    int          cyc;    // value of cyc at the falling edge where ack is seen
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input bit port, input bit we, input logic [20:0] addr,
                      input logic [7:0] rdata, input int ack_cyc);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.rdata = rdata;
    e.cyc   = ack_cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: accumulates per-transaction strobe statistics and checks each ack
  // against the head of the queue.
  initial begin
    int          we_cnt      = 0;
    int          oe_cnt      = 0;
    bit          addr_moved  = 1'b0;
    bit          prev_we_low = 1'b0;
    logic [20:0] prev_addr   = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        we_cnt      = 0;
        oe_cnt      = 0;
        addr_moved  = 1'b0;
        prev_we_low = 1'b0;
      end else begin
        if (!sram_we_n) we_cnt++;
        if (sram_oe)    oe_cnt++;
        if (!sram_we_n && prev_we_low && sram_addr !== prev_addr) addr_moved = 1'b1;
        prev_we_low = !sram_we_n;
        prev_addr   = sram_addr;

        if (a_ack || b_ack) begin
          check("single_ack", 32'(a_ack && b_ack), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_port",      32'(b_ack),      32'(e.port));
            check("ack_cycle",     32'(cyc),        32'(e.cyc));
            check("sram_addr",     32'(sram_addr),  32'(e.addr));
            check("we_low_cycles", 32'(we_cnt),     e.we ? 32'(W) : 32'd0);
            check("oe_cycles",     32'(oe_cnt),     e.we ? 32'(W + 2) : 32'd0);
            check("addr_stable",   32'(addr_moved), 32'd0);
            if (!e.we) check("rdata", 32'(e.port ? b_rdata : a_rdata), 32'(e.rdata));
          end
          we_cnt     = 0;
          oe_cnt     = 0;
          addr_moved = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Wait (bounded) for the given port's ack, then drop its request.
  task automatic wait_ack(input bit port);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (port == 1'b0 && a_ack) begin a_req = 1'b0; seen = 1'b1; end
      if (port == 1'b1 && b_ack) begin b_req = 1'b0; seen = 1'b1; end
    end
    if (!seen) begin
      check(port ? "b_ack_timeout" : "a_ack_timeout", 32'd0, 32'd1);
      a_req = 1'b0;
      b_req = 1'b0;
    end
  endtask

  // One transaction with the arbiter idle. The request is raised at a falling
  // edge, sampled on the next rising edge, and ack is seen W+2 falling edges later.
  task automatic txn(input bit port, input bit we, input logic [19:0] addr,
                     input logic [7:0] wdata, input logic [7:0] exp_rd);
    @(negedge clk);
    push(port, we, {1'b0, addr}, exp_rd, cyc + W + 2);
    if (port == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
    wait_ack(port);
  endtask

  // Single write on a parameter-limit instance: strobe width, drive-enable
  // width, address and ack latency.
  task automatic run_limit(input int idx, input int w);
    int  lows = 0;
    int  oes  = 0;
    int  lat  = -1;
    @(negedge clk);
    x_req[idx] = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (!x_we_n[idx]) lows++;
      if (x_oe[idx])    oes++;
      if (x_ack[idx]) begin
        lat = k;
        x_req[idx] = 1'b0;
        check($sformatf("w%0d_addr", w), 32'(x_addr[idx]), 32'h000042);
        check($sformatf("w%0d_dout", w), 32'(x_dout[idx]), 32'h24);
      end
    end
    x_req[idx] = 1'b0;
    check($sformatf("w%0d_ack_latency", w), 32'(lat), 32'(w + 2));
    check($sformatf("w%0d_we_low", w),      32'(lows), 32'(w));
    check($sformatf("w%0d_oe_cycles", w),   32'(oes),  32'(w + 2));
    check($sformatf("w%0d_b_idle", w),
          32'({x_back[idx], x_ardata[idx], x_brdata[idx]}), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c0;
    reset_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    x_req[0] = 1'b0;
    x_req[1] = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("rst_we_n",  32'(sram_we_n), 32'd1);
    check("rst_oe",    32'(sram_oe),   32'd0);
    check("rst_acks",  32'({a_ack, b_ack}), 32'd0);
    check("rst_addr",  32'(sram_addr), 32'd0);
    check("rst_dout",  32'(sram_dout), 32'd0);
    check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Port A write to the upper bank, then read it back.
    txn(1'b0, 1'b1, 20'h80001, 8'h5A, 8'h00);
    txn(1'b0, 1'b0, 20'h80001, 8'h00, 8'h5A);

    // Port B read of a preloaded location; then an A read must leave b_rdata alone.
    txn(1'b1, 1'b0, 20'h00010, 8'h00, 8'hC3);
    txn(1'b0, 1'b0, 20'h00777, 8'h00, 8'hEE);
    check("b_rdata_held", 32'(b_rdata), 32'hC3);

    // Fresh reset so last_grant is B again, then continuous dual requests:
    // A write, B read, A write, B read, acks 5 cycles apart.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    c0 = cyc;
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h00100; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 20'h00100; b_wdata = 8'h00;
    push(1'b0, 1'b1, 21'h000100, 8'h00, c0 + 4);
    push(1'b1, 1'b0, 21'h000100, 8'h11, c0 + 9);
    push(1'b0, 1'b1, 21'h000100, 8'h00, c0 + 14);
    push(1'b1, 1'b0, 21'h000100, 8'h11, c0 + 19);
    repeat (14) @(negedge clk);
    a_req = 1'b0;
    repeat (5) @(negedge clk);
    b_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during ACCESS of a write: strobe released at once, no ack.
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h00200; a_wdata = 8'h77;
    repeat (2) @(negedge clk);
    check("abort_in_access_we_n", 32'(sram_we_n), 32'd0);
    reset_n = 1'b0;
    a_req   = 1'b0;
    @(negedge clk);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe",   32'(sram_oe),   32'd0);
    check("abort_ack",  32'(a_ack),     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    txn(1'b0, 1'b1, 20'h00300, 8'h99, 8'h00);
    txn(1'b1, 1'b0, 20'h00300, 8'h00, 8'h99);

    // Address and data changed during ACCESS must not redirect the write.
    @(negedge clk);
    push(1'b0, 1'b1, 21'h012345, 8'h00, cyc + W + 2);
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h12345; a_wdata = 8'h3C;
    repeat (2) @(negedge clk);
    a_addr  = 20'h00777;
    a_wdata = 8'hFF;
    wait_ack(1'b0);
    txn(1'b1, 1'b0, 20'h12345, 8'h00, 8'h3C);
    txn(1'b0, 1'b0, 20'h00777, 8'h00, 8'hEE);

    // Parameter limits.
    run_limit(0, 1);
    run_limit(1, 15);

    // Drain the scoreboard (bounded).
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
